// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset constants and bus FSM states shared by the CLINT timer
package clint_pkg;
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic {S_IDLE, S_RESP} state_t;
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk by TICK_DIV into a one-cycle mtime tick, frozen by i_stop
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stop,
  input  logic i_clr,
  output logic o_tick
);
  logic [15:0] r_cnt;
  logic        w_last;
  assign w_last = r_cnt == 16'(TICK_DIV - 1);
  assign o_tick = w_last && !i_stop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (!i_stop) r_cnt <= w_last ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: mtime/mtimecmp/msip registers behind a single-cycle-ack slave port, driving MTIP/MSIP levels
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned BASE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [BASE_BITS-1:0] addr,
  input  logic [63:0]          wdata,
  input  logic [7:0]           wstrb,
  output logic [63:0]          rdata,
  output logic                 ack,
  output logic                 bus_err,
  input  logic                 time_stop,
  output logic                 m_time_int,
  output logic                 m_soft_int
);
  state_t               r_state, w_state_nx;
  logic [63:0]          r_mtime, r_mtimecmp, r_rdata, w_rd, w_mask, w_mtime_inc;
  logic                 r_msip, r_err, r_mti, r_msi;
  logic                 w_acc, w_wr, w_tick, w_sel_msip, w_sel_cmp, w_sel_time, w_hit;
  logic [BASE_BITS-1:0] w_off;
  assign w_acc       = (r_state == S_IDLE) && req;
  assign w_wr        = w_acc && we && |wstrb;
  assign w_off       = addr & ~BASE_BITS'(7);
  assign w_sel_msip  = w_off == BASE_BITS'(MSIP_OFF);
  assign w_sel_cmp   = w_off == BASE_BITS'(MTIMECMP_OFF);
  assign w_sel_time  = w_off == BASE_BITS'(MTIME_OFF);
  assign w_hit       = w_sel_msip | w_sel_cmp | w_sel_time;
  assign w_mtime_inc = r_mtime + 64'(w_tick);
  assign w_rd        = w_sel_msip ? {63'd0, r_msip} : w_sel_cmp ? r_mtimecmp : w_sel_time ? r_mtime : '0;
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 8; i++) w_mask[8*i +: 8] = {8{wstrb[i]}};
  end
  always_comb begin
    w_state_nx = S_IDLE;
    w_state_nx = w_acc ? S_RESP : S_IDLE;
  end
  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .i_stop (time_stop),
    .i_clr  (w_wr && w_sel_time),
    .o_tick (w_tick)
  );
  // a write to mtime merges with the ticked value so unstrobed bytes keep counting
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_mti      <= 1'b0;
      r_msi      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rdata <= (w_acc && !we) ? w_rd : '0;
      r_err   <= w_acc && !w_hit;
      r_mtime <= (w_wr && w_sel_time) ? (wdata & w_mask) | (w_mtime_inc & ~w_mask) : w_mtime_inc;
      if (w_wr && w_sel_cmp) r_mtimecmp <= (wdata & w_mask) | (r_mtimecmp & ~w_mask);
      if (w_wr && w_sel_msip && wstrb[0]) r_msip <= wdata[0];
      r_mti <= r_mtime >= r_mtimecmp;
      r_msi <= r_msip;
    end
  assign ack        = r_state == S_RESP;
  assign rdata      = r_rdata;
  assign bus_err    = r_err;
  assign m_time_int = r_mti;
  assign m_soft_int = r_msi;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard bench for clint_timer with TICK_DIV=1 and TICK_DIV=4 instances
module tb_clint_timer;
  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CMP  = 16'h4000;
  localparam logic [15:0] A_TIME = 16'hBFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 0, rst = 1, req = 0, req4 = 0, we = 0, time_stop = 0, sel = 0;
  logic [15:0] addr = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  wstrb = 0;
  logic [63:0] rdata1, rdata4, rdata_m;
  logic        ack1, ack4, err1, err4, mti1, mti4, msi1, msi4, ack_m, err_m;
  int          checks = 0, errors = 0;
  logic [64:0] exp_q[$];

  assign rdata_m = sel ? rdata4 : rdata1;
  assign ack_m   = sel ? ack4 : ack1;
  assign err_m   = sel ? err4 : err1;

  always #5 clk = ~clk;

  clint_timer dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata1), .ack(ack1), .bus_err(err1), .time_stop(time_stop),
    .m_time_int(mti1), .m_soft_int(msi1)
  );
  clint_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata4), .ack(ack4), .bus_err(err4), .time_stop(time_stop),
    .m_time_int(mti4), .m_soft_int(msi4)
  );

  // call at a negedge: request accepted on the next posedge, returns two negedges later
  task automatic xfer(input string tag, input logic w, input logic [15:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic chk, input logic [63:0] exp_rd,
                      input logic exp_err, output logic [63:0] got);
    logic [64:0] e;
    int n;
    exp_q.push_back({exp_err, exp_rd});
    we = w; addr = a; wdata = d; wstrb = s;
    if (sel) req4 = 1; else req = 1;
    @(posedge clk); #1;
    req = 0; req4 = 0;
    n = 0;
    @(negedge clk);
    while (!ack_m && n < 4) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    got = rdata_m;
    checks++;
    if (ack_m !== 1'b1 || n != 0) begin
      errors++; $display("FAIL %s_ack: ack=%b extra_wait=%0d, want ack=1 extra_wait=0", tag, ack_m, n);
    end
    checks++;
    if (err_m !== e[64]) begin
      errors++; $display("FAIL %s_err: bus_err=%b, want %b", tag, err_m, e[64]);
    end
    if (chk) begin
      checks++;
      if (rdata_m !== e[63:0]) begin
        errors++; $display("FAIL %s_rdata: got %h, want %h", tag, rdata_m, e[63:0]);
      end
    end
    @(negedge clk);
    checks++;
    if (ack_m !== 1'b0 || rdata_m !== 64'd0) begin
      errors++; $display("FAIL %s_pulse: ack=%b rdata=%h after one cycle, want ack=0 rdata=0", tag, ack_m, rdata_m);
    end
  endtask

  task automatic test_reset();
    logic [63:0] got;
    int spurious;
    #1 rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack1, err1, mti1, msi1, ack4, err4, mti4, msi4} !== 8'd0 || rdata1 !== 64'd0 || rdata4 !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: ack=%b err=%b mti=%b msi=%b rdata=%h, want all 0", ack1, err1, mti1, msi1, rdata1);
    end
    rst = 1;
    spurious = 0;
    repeat (9) begin @(negedge clk); if (ack1 || ack4) spurious++; end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL reset_idle_ack: %0d ack cycles while idle, want 0", spurious); end
    sel = 0;
    xfer("reset_mtime", 0, A_TIME, 0, 0, 0, 0, 0, got);
    checks++;
    if (got !== 64'd9 && got !== 64'd10) begin errors++; $display("FAIL reset_mtime: got %0d, want 9 or 10", got); end
    checks++;
    if (mti1 !== 1'b0 || msi1 !== 1'b0) begin errors++; $display("FAIL reset_irq: mti=%b msi=%b, want 0 0", mti1, msi1); end
    xfer("reset_cmp", 0, A_CMP, 0, 0, 1, ONES, 0, got);
    xfer("reset_msip", 0, A_MSIP, 0, 0, 1, 0, 0, got);
  endtask

  task automatic test_timer_fire();
    logic [63:0] got;
    sel = 0;
    time_stop = 1;
    xfer("fire_wr_time", 1, A_TIME, 64'd15, 8'hFF, 0, 0, 0, got);
    xfer("fire_wr_cmp", 1, A_CMP, 64'd20, 8'hFF, 0, 0, 0, got);
    time_stop = 0;
    // mtime = 15+k after edge k, hits 20 at edge 5, interrupt registered at edge 6
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (mti1 !== (k >= 6)) begin errors++; $display("FAIL fire_edge%0d: m_time_int=%b, want %b", k, mti1, k >= 6); end
    end
    xfer("fire_clr_cmp", 1, A_CMP, ONES, 8'hFF, 0, 0, 0, got);
    checks++;
    if (mti1 !== 1'b0) begin errors++; $display("FAIL fire_clear: m_time_int=%b, want 0", mti1); end
  endtask

  task automatic test_strobes();
    logic [63:0] got;
    sel = 0;
    time_stop = 1;
    xfer("strb_zero", 1, A_TIME, 0, 8'hFF, 0, 0, 0, got);
    xfer("strb_low", 1, A_TIME, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, got);
    xfer("strb_rd1", 0, A_TIME, 0, 0, 1, 64'h0000_0000_5566_7788, 0, got);
    xfer("strb_none", 1, A_TIME, ONES, 8'h00, 0, 0, 0, got);
    xfer("strb_rd2", 0, A_TIME, 0, 0, 1, 64'h0000_0000_5566_7788, 0, got);
    xfer("strb_cmp", 1, A_CMP, 64'hAAAA_AAAA_0000_0000, 8'hF0, 0, 0, 0, got);
    xfer("strb_rd3", 0, A_CMP, 0, 0, 1, 64'hAAAA_AAAA_FFFF_FFFF, 0, got);
  endtask

  task automatic test_wrap();
    logic [63:0] got;
    sel = 0;
    time_stop = 1;
    xfer("wrap_time", 1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 0, 0, got);
    xfer("wrap_cmp", 1, A_CMP, ONES, 8'hFF, 0, 0, 0, got);
    checks++;
    if (mti1 !== 1'b0) begin errors++; $display("FAIL wrap_pre: m_time_int=%b, want 0", mti1); end
    time_stop = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (mti1 !== (k == 2)) begin errors++; $display("FAIL wrap_edge%0d: m_time_int=%b, want %b", k, mti1, k == 2); end
    end
    time_stop = 1;
    xfer("wrap_rd", 0, A_TIME, 0, 0, 1, 64'd3, 0, got);
  endtask

  task automatic test_soft_err();
    logic [63:0] got;
    sel = 0;
    xfer("sw_set", 1, A_MSIP, 64'hFFFF_FFFF, 8'hFF, 0, 0, 0, got);
    checks++;
    if (msi1 !== 1'b1) begin errors++; $display("FAIL sw_int_set: m_soft_int=%b, want 1", msi1); end
    xfer("sw_rd", 0, A_MSIP, 0, 0, 1, 64'd1, 0, got);
    xfer("sw_hi_strb", 1, A_MSIP, 0, 8'hFE, 0, 0, 0, got);
    xfer("sw_rd2", 0, A_MSIP, 0, 0, 1, 64'd1, 0, got);
    xfer("err_rd", 0, 16'h0100, 0, 0, 1, 64'd0, 1, got);
    xfer("err_wr", 1, 16'h0100, ONES, 8'hFF, 0, 0, 1, got);
    xfer("alias_cmp", 0, 16'h4007, 0, 0, 1, ONES, 0, got);
    xfer("sw_clr", 1, A_MSIP, 0, 8'h01, 0, 0, 0, got);
    checks++;
    if (msi1 !== 1'b0) begin errors++; $display("FAIL sw_int_clr: m_soft_int=%b, want 0", msi1); end
  endtask

  task automatic test_prescaler();
    logic [63:0] got;
    sel = 1;
    time_stop = 1;
    xfer("div_zero", 1, A_TIME, 0, 8'hFF, 0, 0, 0, got);
    time_stop = 0;
    @(negedge clk);
    // ticks land on edges 4, 8, 12, 16 after release; the write lands on edge 8
    xfer("div_e2", 0, A_TIME, 0, 0, 1, 64'd0, 0, got);
    xfer("div_e4", 0, A_TIME, 0, 0, 1, 64'd0, 0, got);
    xfer("div_e6", 0, A_TIME, 0, 0, 1, 64'd1, 0, got);
    xfer("div_wr", 1, A_TIME, 64'd100, 8'hFF, 0, 0, 0, got);
    xfer("div_e10", 0, A_TIME, 0, 0, 1, 64'd100, 0, got);
    xfer("div_e12", 0, A_TIME, 0, 0, 1, 64'd100, 0, got);
    @(negedge clk);
    xfer("div_e15", 0, A_TIME, 0, 0, 1, 64'd101, 0, got);
    xfer("div_e17", 0, A_TIME, 0, 0, 1, 64'd102, 0, got);
    sel = 0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    sel = 0;
    time_stop = 1;
    we = 1; addr = A_CMP; wdata = 64'd5; wstrb = 8'hFF; req = 1;
    @(posedge clk); #1;
    req = 0;
    checks++;
    if (ack1 !== 1'b1) begin errors++; $display("FAIL mid_ack_before: ack=%b, want 1", ack1); end
    #2 rst = 0;
    #1;
    checks++;
    if (ack1 !== 1'b0) begin errors++; $display("FAIL mid_ack_drop: ack=%b, want 0", ack1); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    xfer("mid_cmp", 0, A_CMP, 0, 0, 1, ONES, 0, got);
    xfer("mid_time", 0, A_TIME, 0, 0, 1, 64'd0, 0, got);
  endtask

  initial begin
    test_reset();
    test_timer_fire();
    test_strobes();
    test_wrap();
    test_soft_err();
    test_prescaler();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/clint_timer.md
# clint_timer

Machine timer and software-interrupt source for the single-hart core. Holds the 64-bit `mtime` counter, `mtimecmp` compare register and `msip` bit behind a simple memory-mapped slave port. Produces the level interrupt lines `m_time_int` and `m_soft_int` that the mip/sip CSR stage samples every cycle into MTIP/MSIP.

## Interface
Parameters:
- `TICK_DIV`, default 1: core clocks per `mtime` increment; legal range 1..65535.
- `BASE_BITS`, default 16: number of low address bits decoded; upper bits are ignored.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low. Assertion clears state immediately; deassertion is synchronous to `clk`.
- `req`  in  1  bus request; held high until `ack`.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  BASE_BITS  byte address; bits [2:0] ignored (64-bit aligned).
- `wdata`  in  64  write data.
- `wstrb`  in  8  byte enables for writes.
- `rdata`  out  64  read data; valid while `ack` = 1, otherwise 0.
- `ack`  out  1  single-cycle completion pulse.
- `bus_err`  out  1  pulses with `ack` for an unmapped address.
- `time_stop`  in  1  debug halt; freezes `mtime` and the prescaler while high.
- `m_time_int`  out  1  level, `mtime >= mtimecmp` (unsigned).
- `m_soft_int`  out  1  level, equals `msip`.

## Operation
- Register map (offset, masked to BASE_BITS): 0x0000 `msip`, bit 0 only, other bits read 0 and ignore writes; 0x4000 `mtimecmp`; 0xBFF8 `mtime`. Any other offset is unmapped.
- Writes honour `wstrb` per byte. A write with `wstrb` = 0 completes with `ack` and changes nothing.
- Unmapped address: write ignored, read returns 0, `ack` = 1 and `bus_err` = 1 in the same cycle.
- Bus FSM: IDLE → RESP when `req` = 1 in IDLE. The access executes on that edge. RESP → IDLE unconditionally. `req` is not sampled in RESP.
- Prescaler: counts 0..TICK_DIV-1. `mtime` increments by 1 on the edge where the prescaler equals TICK_DIV-1 and `time_stop` = 0. With TICK_DIV = 1, `mtime` increments every cycle.
- `mtime` wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
- A bus write to `mtime` in the same cycle as a tick wins: the written bytes take the write value and unwritten bytes take the incremented value. The prescaler resets to 0 on any `mtime` write.
- `m_time_int` and `m_soft_int` are registered from current register values. They are never cleared except by register change.

## Timing
- Reset values: `mtime` = 0, prescaler = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, `msip` = 0, FSM = IDLE. All outputs are 0.
- Access latency: with `req` seen in IDLE in cycle N, the write takes effect at the end of cycle N. `ack` and `rdata` are valid in cycle N+1. The earliest next acceptance is N+2.
- Read data is the register value at the end of cycle N, before that edge's tick.
- Interrupt latency: a register change at the end of cycle N is reflected on `m_time_int` / `m_soft_int` at the end of cycle N+1.
- Reset asserted mid-access: `ack` drops immediately and the access is lost. Register state returns to its reset values.

## Structure
- `clint_pkg` holds the offsets `MSIP_OFF`, `MTIMECMP_OFF` and `MTIME_OFF`, the `mtimecmp` reset constant, and the FSM state enum.
- Sub-module `clint_prescaler` contains the TICK_DIV counter plus the `time_stop` gating and outputs a `tick` pulse. The bus FSM, registers and compare logic live in the top module.

## Test plan
- Reset: release `rst`, then idle 10 cycles with TICK_DIV = 1. Required: `mtime` reads 9 or 10, `m_time_int` = 0, `m_soft_int` = 0, and every `ack` is a one-cycle pulse.
- Timer fire: write `mtimecmp` = 20 and wait. Required: `m_time_int` rises exactly one cycle after `mtime` reaches 20. Then write `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF. Required: `m_time_int` = 0 two cycles after the write's request.
- Byte strobes: write `mtime` = 0x1122_3344_5566_7788 with `wstrb` = 0x0F, over a frozen `mtime` = 0 (`time_stop` = 1). Required: readback = 0x0000_0000_5566_7788.
- Wrap: with `time_stop` = 1, write `mtime` = 0xFFFF_FFFF_FFFF_FFFE and `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, then release `time_stop`. Required: `m_time_int` is 1 for exactly one cycle, then `mtime` wraps to 0 and `m_time_int` returns to 0.
- Software interrupt and error: write 0xFFFF_FFFF to `msip`. Required: readback = 1 and `m_soft_int` = 1. Read offset 0x0100. Required: `rdata` = 0 and `bus_err` = 1 with `ack`.
- Prescaler plus collision: with TICK_DIV = 4, `mtime` advances once per 4 cycles. A write of 100 to `mtime` on a tick edge reads back as 100, and the next increment follows 4 cycles later.
